seven_seg_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment scan controller, the successor to the fixed 6-digit, clock-per-digit mux timing generator in the display path. It drives the digit-select index for the segment data mux and the one-hot anode enables. It adds a refresh prescaler, an anti-ghosting blanking interval between digits, per-digit enable masking with skip, selectable anode polarity, and a frame-start pulse for display-buffer update sync.

---
 rtl/seven_seg_pkg.sv | 23 ++
 rtl/seven_seg_next_digit.sv | 43 ++++
 rtl/seven_seg_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan controller: state codes and width/polarity helpers.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package seven_seg_pkg;

  // Scan FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  localparam int MAX_DIGITS = 16;

  // Bits needed to hold an index 0..n-1, never less than one bit
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Anode level for "all digits off" across n digits, for either polarity
  function automatic logic [MAX_DIGITS-1:0] anode_inactive(input bit active_low, input int n);
    return active_low ? MAX_DIGITS'((32'd1 << n) - 32'd1) : '0;
  endfunction

endpackage

// File: rtl/seven_seg_next_digit.sv
// Picks the next digit to scan: lowest enabled index above cur_idx, else the lowest enabled overall.
// Latency: purely combinational.
// Backpressure: none.
module seven_seg_next_digit
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SEL_W      = sel_width(NUM_DIGITS)
) (
  input  logic [SEL_W-1:0]      cur_idx,
  input  logic [NUM_DIGITS-1:0] mask,
  output logic [SEL_W-1:0]      next_idx,
  output logic                  wrap,
  output logic                  any_enabled
);

  logic [SEL_W-1:0] above_idx;
  logic [SEL_W-1:0] low_idx;
  logic             found_above;
  logic             found_low;

  // Priority scan from bit 0 upward; first hit wins for both searches
  always_comb begin
    above_idx   = '0;
    low_idx     = '0;
    found_above = 1'b0;
    found_low   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (mask[i] && !found_low) begin
        low_idx   = SEL_W'(i);
        found_low = 1'b1;
      end
      if (mask[i] && !found_above && (SEL_W'(i) > cur_idx)) begin
        above_idx   = SEL_W'(i);
        found_above = 1'b1;
      end
    end
    wrap        = !found_above;
    next_idx    = found_above ? above_idx : low_idx;
    any_enabled = found_low;
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan: blank interval then one-hot anode per enabled digit, frame_start on wrap.
// Latency: all outputs registered; first anode on BLANK_CYCLES+1 cycles after enable with a non-zero mask.
// Backpressure: none; free-running while enable=1, enable=0 parks in IDLE with anodes off.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int  NUM_DIGITS       = 6,
  parameter int  CLK_DIV          = 1000,
  parameter int  BLANK_CYCLES     = 16,
  parameter bit  ANODE_ACTIVE_LOW = 1'b0,
  localparam int SEL_W            = sel_width(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  output logic [SEL_W-1:0]      mux_sel,
  output logic [NUM_DIGITS-1:0] addr,
  output logic                  frame_start,
  output logic                  scan_active
);

  // One counter serves both phases, so it is sized for the longer one
  localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CNT_W   = sel_width(CNT_MAX);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);
  localparam logic [NUM_DIGITS-1:0] ADDR_OFF = NUM_DIGITS'(anode_inactive(ANODE_ACTIVE_LOW, NUM_DIGITS));
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_DIGITS - 1);

  function automatic logic [NUM_DIGITS-1:0] anode_on(input logic [SEL_W-1:0] idx);
    return (NUM_DIGITS'(1) << idx) ^ ADDR_OFF;
  endfunction

  logic [1:0]            state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [SEL_W-1:0]      sel_n;
  logic [NUM_DIGITS-1:0] addr_n;
  logic                  fs_n;
  logic [SEL_W-1:0]      cur_idx;
  logic [SEL_W-1:0]      next_idx;
  logic                  wrap;
  logic                  any_enabled;

  // From IDLE, searching above the top index yields the lowest enabled digit
  assign cur_idx = (state == ST_IDLE) ? LAST_IDX : mux_sel;

  seven_seg_next_digit #(
    .NUM_DIGITS (NUM_DIGITS),
    .SEL_W      (SEL_W)
  ) u_next (
    .cur_idx     (cur_idx),
    .mask        (digit_mask),
    .next_idx    (next_idx),
    .wrap        (wrap),
    .any_enabled (any_enabled)
  );

  // Next-state, next-output decode; mask only matters at IDLE exit and SHOW exit
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    sel_n   = mux_sel;
    addr_n  = ADDR_OFF;
    fs_n    = 1'b0;
    if (!enable) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_n = '0;
          if (any_enabled) begin
            sel_n = next_idx;
            fs_n  = 1'b1;
            if (HAS_BLANK) begin
              state_n = ST_BLANK;
            end else begin
              state_n = ST_SHOW;
              addr_n  = anode_on(next_idx);
            end
          end
        end
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_n = ST_SHOW;
            cnt_n   = '0;
            addr_n  = anode_on(mux_sel);
          end
        end
        ST_SHOW: begin
          addr_n = anode_on(mux_sel);
          if (cnt == SHOW_LAST) begin
            cnt_n = '0;
            if (!any_enabled) begin
              state_n = ST_IDLE;
              addr_n  = ADDR_OFF;
            end else begin
              sel_n = next_idx;
              fs_n  = wrap;
              if (HAS_BLANK) begin
                state_n = ST_BLANK;
                addr_n  = ADDR_OFF;
              end else begin
                state_n = ST_SHOW;
                addr_n  = anode_on(next_idx);
              end
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // State and output registers; reset drops every output immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      mux_sel     <= '0;
      addr        <= ADDR_OFF;
      frame_start <= 1'b0;
      scan_active <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      mux_sel     <= sel_n;
      addr        <= addr_n;
      frame_start <= fs_n;
      scan_active <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: active-high instance with blanking, active-low instance without.
// Latency: n/a.
// Backpressure: n/a.
module tb_seven_seg_scan_ctrl;

  logic       clk;
  logic       reset;
  logic       enable, enable_al;
  logic [5:0] mask, mask_al;
  logic [2:0] mux, mux_al;
  logic [5:0] addr, addr_al;
  logic       fs, fs_al;
  logic       act, act_al;

  int vectors     = 0;
  int miscompares = 0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS (6), .CLK_DIV (4), .BLANK_CYCLES (2), .ANODE_ACTIVE_LOW (1'b0)
  ) dut (
    .clk (clk), .reset (reset), .enable (enable), .digit_mask (mask),
    .mux_sel (mux), .addr (addr), .frame_start (fs), .scan_active (act)
  );

  seven_seg_scan_ctrl #(
    .NUM_DIGITS (6), .CLK_DIV (4), .BLANK_CYCLES (0), .ANODE_ACTIVE_LOW (1'b1)
  ) dut_al (
    .clk (clk), .reset (reset), .enable (enable_al), .digit_mask (mask_al),
    .mux_sel (mux_al), .addr (addr_al), .frame_start (fs_al), .scan_active (act_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int dig;
    reset     = 1'b0;
    enable    = 1'b0;
    enable_al = 1'b0;
    mask      = 6'h3F;
    mask_al   = 6'h00;
    #1 reset  = 1'b1;
    #2;
    check("rst_addr", addr, 32'h00);
    check("rst_mux", mux, 32'd0);
    check("rst_fs", fs, 32'd0);
    check("rst_act", act, 32'd0);
    check("rst_addr_al", addr_al, 32'h3F);
    enable = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Full mask: 2 blank + 4 show per digit, 36-cycle frame
    for (int t = 0; t < 38; t++) begin
      tick();
      dig = (t / 6) % 6;
      check("s1_mux", mux, dig);
      check("s1_addr", addr, ((t % 6) >= 2) ? (32'd1 << dig) : 32'd0);
      check("s1_fs", fs, (t % 36) == 0);
    end

    // Sparse mask 0x24: digits 2 and 5 alternate, 12-cycle frame
    enable = 1'b0;
    tick();
    check("s2_idle_act", act, 32'd0);
    check("s2_idle_addr", addr, 32'h00);
    mask   = 6'h24;
    enable = 1'b1;
    for (int s = 0; s < 26; s++) begin
      tick();
      dig = (((s / 6) % 2) == 0) ? 2 : 5;
      check("s2_mux", mux, dig);
      check("s2_addr", addr, ((s % 6) >= 2) ? (32'd1 << dig) : 32'd0);
      check("s2_fs", fs, (s % 12) == 0);
    end

    // Mask cleared while digit 3 is lit: it finishes, then IDLE
    enable = 1'b0;
    tick();
    mask   = 6'h3F;
    enable = 1'b1;
    repeat (21) tick();
    check("s3_addr_t20", addr, 32'h08);
    check("s3_mux_t20", mux, 32'd3);
    tick();
    mask = 6'h00;
    tick();
    check("s3_addr_t22", addr, 32'h08);
    tick();
    check("s3_addr_t23", addr, 32'h08);
    check("s3_act_t23", act, 32'd1);
    tick();
    check("s3_addr_t24", addr, 32'h00);
    check("s3_act_t24", act, 32'd0);
    check("s3_mux_t24", mux, 32'd3);
    check("s3_fs_t24", fs, 32'd0);
    tick();
    check("s3_act_t25", act, 32'd0);

    // Enable dropped in the blank before digit 1, re-raised 10 cycles later
    mask = 6'h3F;
    repeat (7) tick();
    check("s4_mux_blank", mux, 32'd1);
    check("s4_addr_blank", addr, 32'h00);
    check("s4_act_blank", act, 32'd1);
    enable = 1'b0;
    tick();
    check("s4_act_off", act, 32'd0);
    check("s4_mux_held", mux, 32'd1);
    check("s4_addr_off", addr, 32'h00);
    repeat (9) begin
      tick();
      check("s4_addr_dis", addr, 32'h00);
    end
    enable = 1'b1;
    tick();
    check("s4_mux_restart", mux, 32'd0);
    check("s4_fs_restart", fs, 32'd1);
    check("s4_addr_r0", addr, 32'h00);
    tick();
    check("s4_addr_r1", addr, 32'h00);
    tick();
    check("s4_addr_r2", addr, 32'h01);

    // Active-low, no blanking, single digit: digit 0 held on, wrap every 4 cycles
    check("s5_addr_al_idle", addr_al, 32'h3F);
    mask_al   = 6'h01;
    enable_al = 1'b1;
    for (int s = 0; s < 13; s++) begin
      tick();
      check("s5_addr_al", addr_al, 32'h3E);
      check("s5_mux_al", mux_al, 32'd0);
      check("s5_fs_al", fs_al, (s % 4) == 0);
    end

    // Asynchronous reset in mid-SHOW (main dut on digit 2, active-low dut pulsing frame_start)
    check("s6_pre_addr", addr, 32'h04);
    check("s6_pre_mux", mux, 32'd2);
    #2 reset = 1'b1;
    #1;
    check("s6_addr", addr, 32'h00);
    check("s6_mux", mux, 32'd0);
    check("s6_fs", fs, 32'd0);
    check("s6_act", act, 32'd0);
    check("s6_addr_al", addr_al, 32'h3F);
    check("s6_fs_al", fs_al, 32'd0);
    check("s6_act_al", act_al, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
